// File: rtl/axis_bad_pix_replacer.sv
// Streaming bad-pixel replacer. Consumes a bordered, flagged frame,
// builds a 3x3 neighbourhood from two line buffers and emits the active
// frame with every flagged pixel replaced by an interpolation of its good
// 4-connected neighbours. Flags are cleared on output.
module axis_bad_pix_replacer #(
    parameter int IMG_RES_X = 336,
    parameter int IMG_RES_Y = 256,
    parameter int BAD_BIT   = 15
) (
    input  logic        axis_aclk,
    input  logic        axis_aresetn,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        row_err,
    output logic [23:0] bad_cnt
);

    localparam int COLS = IMG_RES_X + 2;
    localparam int ROWS = IMG_RES_Y + 2;
    localparam int CW   = $clog2(COLS);
    localparam int RW   = $clog2(ROWS);

    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(2);
    localparam logic [RW-1:0] ROW_FIRST = RW'(2);
    localparam logic [15:0]   FLAG      = 16'h1 << BAD_BIT;

    // Frame boundaries come from the row-end marker on tuser; tlast is not used.
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

    function automatic logic [15:0] strip(input logic [15:0] v);
        return v & ~FLAG;
    endfunction

    // Mean of two pixels with flags masked off; 17-bit sum, truncating shift.
    function automatic logic [15:0] avg2(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, strip(a)} + {1'b0, strip(b)};
        return s[16:1];
    endfunction

    // Horizontal pair first, then vertical pair, else the unflagged centre.
    function automatic logic [15:0] replace(input logic [15:0] c, input logic [15:0] l,
                                            input logic [15:0] r, input logic [15:0] u,
                                            input logic [15:0] d);
        logic gl, gr, gu, gd;
        gl = !l[BAD_BIT];
        gr = !r[BAD_BIT];
        gu = !u[BAD_BIT];
        gd = !d[BAD_BIT];
        if (!c[BAD_BIT])  return strip(c);
        else if (gl && gr) return avg2(l, r);
        else if (gl)       return strip(l);
        else if (gr)       return strip(r);
        else if (gu && gd) return avg2(u, d);
        else if (gu)       return strip(u);
        else if (gd)       return strip(d);
        else               return strip(c);
    endfunction

    logic [CW-1:0] col, col_nxt;
    logic [RW-1:0] row, row_nxt;
    logic [15:0]   lb0 [COLS];
    logic [15:0]   lb1 [COLS];
    logic [15:0]   lb0_rd, lb1_rd;

    // Window taps. The outermost column only ever supplies its middle row
    // (the left neighbour), so its top/bottom rows are not stored; the
    // incoming column is used directly (right neighbour) before it shifts in.
    logic [15:0]   win_mid1;
    logic [15:0]   win_top2, win_mid2, win_bot2;

    logic          hs, produce, row_end, cen_bad, eof_acc;
    logic [15:0]   pix_out;
    logic [23:0]   bad_acc;

    assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    assign hs            = s_axis_tvalid & s_axis_tready;
    assign produce       = (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign lb0_rd        = lb0[col];
    assign lb1_rd        = lb1[col];
    assign cen_bad       = win_mid2[BAD_BIT];
    assign pix_out       = replace(win_mid2, win_mid1, lb1_rd, win_top2, win_bot2);
    assign eof_acc       = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign row_end       = s_axis_tuser || (col == COL_LAST);

    // Next column/row: a tuser marker always closes the row, even early.
    always_comb begin
        col_nxt = col + CW'(1);
        row_nxt = row;
        if (row_end) begin
            col_nxt = '0;
            row_nxt = (row == ROW_LAST) ? '0 : row + RW'(1);
        end
    end

    // Input position counters and sticky row-alignment error.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            col     <= '0;
            row     <= '0;
            row_err <= 1'b0;
        end else if (hs) begin
            col <= col_nxt;
            row <= row_nxt;
            if (s_axis_tuser ^ (col == COL_LAST))
                row_err <= 1'b1;
        end
    end

    // Line buffers: LB1 keeps the previous row, LB0 the one before it.
    always_ff @(posedge axis_aclk) begin
        if (hs) begin
            lb0[col] <= lb1_rd;
            lb1[col] <= s_axis_tdata;
        end
    end

    // Window shift: the incoming column becomes the newest, newest becomes older.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            win_mid1 <= '0;
            win_top2 <= '0;
            win_mid2 <= '0;
            win_bot2 <= '0;
        end else if (hs) begin
            win_mid1 <= win_mid2;
            win_top2 <= lb0_rd;
            win_mid2 <= lb1_rd;
            win_bot2 <= s_axis_tdata;
        end
    end

    // Output register: loads on a producing handshake, drains when accepted.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (hs && produce) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= pix_out;
            m_axis_tlast  <= (row == ROW_LAST) && (col == COL_LAST);
            m_axis_tuser  <= (row == ROW_FIRST) && (col == COL_FIRST);
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Saturating per-frame bad-pixel count, published when EOF is accepted.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            bad_acc <= '0;
            bad_cnt <= '0;
        end else begin
            if (eof_acc) begin
                bad_cnt <= bad_acc;
                bad_acc <= (hs && produce && cen_bad) ? 24'd1 : 24'd0;
            end else if (hs && produce && cen_bad && (bad_acc != '1)) begin
                bad_acc <= bad_acc + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_bad_pix_replacer.sv
// Bench for axis_bad_pix_replacer on a 4x3 active frame. A frame-level
// model derives each output pixel from the bordered image by the
// neighbour-priority rules; the DUT stream is compared against it.
module tb_axis_bad_pix_replacer;

    localparam int X    = 4;
    localparam int Y    = 3;
    localparam int COLS = X + 2;
    localparam int ROWS = Y + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_tdata = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic [15:0] m_tdata;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_tlast;
    logic        m_tuser;
    logic        row_err;
    logic [23:0] bad_cnt;

    int checks = 0;
    int errors = 0;

    logic [16:0] in_q[$];
    logic [17:0] exp_q[$];
    int          exp_bad;
    logic [15:0] img [Y][X];

    axis_bad_pix_replacer #(.IMG_RES_X(X), .IMG_RES_Y(Y), .BAD_BIT(15)) dut (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready),
        .s_axis_tlast (s_tlast),
        .s_axis_tuser (s_tuser),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready),
        .m_axis_tlast (m_tlast),
        .m_axis_tuser (m_tuser),
        .row_err      (row_err),
        .bad_cnt      (bad_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bpx(int r, int c);
        if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) return 16'h8000;
        return img[r-1][c-1];
    endfunction

    function automatic bit good(logic [15:0] v);
        return !v[15];
    endfunction

    function automatic int val(logic [15:0] v);
        return int'(v[14:0]);
    endfunction

    task automatic fill_ramp();
        for (int r = 0; r < Y; r++)
            for (int c = 0; c < X; c++)
                img[r][c] = 16'(r * X + c + 1);
    endtask

    task automatic fill_random(input int pct);
        for (int r = 0; r < Y; r++)
            for (int c = 0; c < X; c++)
                img[r][c] = 16'($urandom_range(0, 32767)) |
                            (($urandom_range(0, 99) < pct) ? 16'h8000 : 16'h0000);
    endtask

    // Queue the bordered stream and the expected active-frame stream.
    task automatic load_frame(input int no_tuser_row);
        logic [15:0] pc, pl, pr, pu, pd;
        int o;
        exp_bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                in_q.push_back({(c == COLS - 1) && (r != no_tuser_row), bpx(r, c)});
        for (int r = 0; r < Y; r++) begin
            for (int c = 0; c < X; c++) begin
                pc = bpx(r + 1, c + 1);
                pl = bpx(r + 1, c);
                pr = bpx(r + 1, c + 2);
                pu = bpx(r, c + 1);
                pd = bpx(r + 2, c + 1);
                if (good(pc)) o = val(pc);
                else begin
                    exp_bad++;
                    if (good(pl) && good(pr))      o = (val(pl) + val(pr)) / 2;
                    else if (good(pl))             o = val(pl);
                    else if (good(pr))             o = val(pr);
                    else if (good(pu) && good(pd)) o = (val(pu) + val(pd)) / 2;
                    else if (good(pu))             o = val(pu);
                    else if (good(pd))             o = val(pd);
                    else                           o = val(pc);
                end
                exp_q.push_back({16'(o), (r == 0 && c == 0), (r == Y - 1 && c == X - 1)});
            end
        end
    endtask

    // Stream in_q into the DUT with random valid/ready; optionally check outputs.
    task automatic run(input string name, input int vpct, input int rpct, input bit chk,
                       output int cyc);
        bit keep = 0;
        bit stalled = 0;
        logic [17:0] held = '0;
        logic [17:0] got, exp;
        int n = 0;
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (!keep) begin
                if (in_q.size() > 0 && $urandom_range(0, 99) < vpct) begin
                    s_valid = 1'b1;
                    {s_tuser, s_tdata} = in_q[0];
                    keep = 1;
                end else begin
                    s_valid = 1'b0;
                    s_tuser = 1'b0;
                end
            end
            m_ready = ($urandom_range(0, 99) < rpct);
            s_tlast = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (s_valid && s_ready) begin
                in_q.delete(0);
                keep = 0;
            end
            got = {m_tdata, m_tuser, m_tlast};
            if (stalled) begin
                checks++;
                if (!m_valid || got !== held) begin
                    errors++;
                    $display("FAIL %s stall hold: got valid=%b %h, expected valid=1 %h",
                             name, m_valid, got, held);
                end
            end
            stalled = 0;
            if (m_valid && m_ready) begin
                if (chk) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s extra output: got data=%h, expected none", name, m_tdata);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL %s pix %0d: got data=%h user=%b last=%b, expected data=%h user=%b last=%b",
                                     name, n, got[17:2], got[1], got[0], exp[17:2], exp[1], exp[0]);
                        end
                        n++;
                    end
                end
            end else if (m_valid) begin
                stalled = 1;
                held = got;
            end
            if (in_q.size() == 0 && !keep && !s_valid && (chk ? exp_q.size() == 0 : !m_valid))
                break;
            if (cyc >= 3000) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: got %0d inputs and %0d outputs left, expected 0",
                         name, in_q.size(), exp_q.size());
                in_q.delete();
                exp_q.delete();
                break;
            end
        end
        s_valid = 1'b0;
        s_tuser = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic check_bad_cnt(input string name);
        @(posedge clk); @(negedge clk);
        checks++;
        if (bad_cnt !== 24'(exp_bad)) begin
            errors++;
            $display("FAIL %s bad_cnt: got %0d, expected %0d", name, bad_cnt, exp_bad);
        end
    endtask

    task automatic check_row_err(input string name, input logic exp);
        checks++;
        if (row_err !== exp) begin
            errors++;
            $display("FAIL %s row_err: got %b, expected %b", name, row_err, exp);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s valid/ready: got %b/%b, expected 0/1", name, m_valid, s_ready);
        end
        checks++;
        if (m_tdata !== 16'h0) begin
            errors++;
            $display("FAIL %s tdata: got %h, expected 0000", name, m_tdata);
        end
        checks++;
        if ({m_tlast, m_tuser, row_err} !== 3'b000) begin
            errors++;
            $display("FAIL %s last/user/row_err: got %b, expected 000", name, {m_tlast, m_tuser, row_err});
        end
        checks++;
        if (bad_cnt !== 24'h0) begin
            errors++;
            $display("FAIL %s bad_cnt: got %0d, expected 0", name, bad_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset");
    endtask

    task automatic test_ramp();
        int cyc;
        fill_ramp();
        load_frame(-1);
        run("ramp", 100, 100, 1'b1, cyc);
        checks++;
        if (cyc !== COLS * ROWS + 1) begin
            errors++;
            $display("FAIL ramp throughput: got %0d cycles, expected %0d", cyc, COLS * ROWS + 1);
        end
        check_bad_cnt("ramp");
        check_row_err("ramp", 1'b0);
    endtask

    task automatic test_replace_lr();
        int cyc;
        fill_ramp();
        img[1][1] = 16'h8000 | 16'd99;
        load_frame(-1);
        run("replace_lr", 100, 100, 1'b1, cyc);
        check_bad_cnt("replace_lr");
    endtask

    task automatic test_edges();
        int cyc;
        fill_ramp();
        img[0][0] = 16'h8000 | img[0][0];
        img[1][0] = 16'h8000 | img[1][0];
        img[1][1] = 16'h8000 | img[1][1];
        img[1][2] = 16'h8000 | img[1][2];
        load_frame(-1);
        run("edges", 100, 100, 1'b1, cyc);
        check_bad_cnt("edges");
    endtask

    task automatic test_random_stall();
        int cyc;
        int pct[3] = '{25, 60, 90};
        for (int f = 0; f < 3; f++) begin
            fill_random(pct[f]);
            load_frame(-1);
            run("random_stall", 70, 50, 1'b1, cyc);
            check_bad_cnt("random_stall");
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        for (int f = 0; f < 2; f++) begin
            fill_random(40);
            load_frame(-1);
        end
        exp_bad = 0;
        run("back_to_back", 100, 100, 1'b1, cyc);
        checks++;
        if (cyc !== 2 * COLS * ROWS + 1) begin
            errors++;
            $display("FAIL back_to_back throughput: got %0d cycles, expected %0d", cyc, 2 * COLS * ROWS + 1);
        end
    endtask

    task automatic test_row_misalign();
        int cyc;
        fill_ramp();
        in_q.delete();
        exp_q.delete();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!(r == 2 && c > 3))
                    in_q.push_back({(c == COLS - 1) || (r == 2 && c == 3), bpx(r, c)});
        run("misalign", 100, 100, 1'b0, cyc);
        check_row_err("misalign", 1'b1);
        fill_ramp();
        load_frame(-1);
        run("realign", 100, 70, 1'b1, cyc);
        check_bad_cnt("realign");
        check_row_err("realign", 1'b1);
    endtask

    task automatic test_reset_mid();
        int cyc;
        fill_ramp();
        in_q.delete();
        exp_q.delete();
        load_frame(-1);
        m_ready = 1'b1;
        for (int i = 0; i < 2 * COLS + 4; i++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            {s_tuser, s_tdata} = in_q.pop_front();
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_tuser = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_tdata !== 16'd2) begin
            errors++;
            $display("FAIL reset_mid pre: got valid=%b data=%h, expected valid=1 data=0002", m_valid, m_tdata);
        end
        #1 rst_n = 1'b0;
        #1;
        check_idle("reset_mid");
        @(posedge clk); #2;
        rst_n = 1'b1;
        in_q.delete();
        exp_q.delete();
        load_frame(-1);
        run("after_reset_mid", 100, 100, 1'b1, cyc);
        check_bad_cnt("after_reset_mid");
        check_row_err("after_reset_mid", 1'b0);
    endtask

    task automatic test_missing_tuser();
        int cyc;
        fill_random(30);
        load_frame(1);
        run("missing_tuser", 80, 80, 1'b1, cyc);
        check_bad_cnt("missing_tuser");
        check_row_err("missing_tuser", 1'b1);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_replace_lr();
        test_edges();
        test_random_stall();
        test_back_to_back();
        test_row_misalign();
        test_reset_mid();
        test_missing_tuser();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_bad_pix_replacer.md
# axis_bad_pix_replacer

Streaming bad-pixel replacement stage that sits directly downstream of the bordered-image generator in the bad-pixel path. It consumes the bordered frame of (IMG_RES_X+2)×(IMG_RES_Y+2) flagged pixels and builds a 3×3 neighbourhood using two line buffers. Each interior pixel whose BAD_BIT is set is replaced by an interpolation of its good 4-connected neighbours. It emits the original IMG_RES_X×IMG_RES_Y frame with flags cleared, SOF on tuser and EOF on tlast.

## Interface
- IMG_RES_X, 336, active columns (bordered row = IMG_RES_X+2)
- IMG_RES_Y, 256, active rows (bordered frame = IMG_RES_Y+2 rows)
- BAD_BIT, 15, tdata bit marking a bad pixel; upstream sets it on all border pixels
- axis_aclk  in  1  single clock
- axis_aresetn  in  1  reset, asynchronous assert, active-low
- s_axis_tdata  in  16  bordered pixel, BAD_BIT = bad flag
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  ignored
- s_axis_tuser  in  1  last pixel of bordered row
- m_axis_tdata  out  16  output pixel, BAD_BIT always 0
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last pixel of frame
- m_axis_tuser  out  1  first pixel of frame (SOF)
- row_err  out  1  sticky: s_axis_tuser misaligned with column counter
- bad_cnt  out  24  bad pixels replaced in last completed frame

## Operation
- Input counters: col C in 0..IMG_RES_X+1, row R in 0..IMG_RES_Y+1. Both advance on each input handshake. C wraps on IMG_RES_X+1. R wraps to 0 after (IMG_RES_Y+1, IMG_RES_X+1).
- Two line buffers, depth IMG_RES_X+2, 16 bits, asynchronous read, addressed by C. LB1 holds row R-1 and LB0 holds row R-2. On each handshake: read both at C, write LB0←LB1[C] and LB1←s_axis_tdata.
- 3×3 window shift registers, three columns by three rows, shifted on each handshake.
- An input handshake at R≥2, C≥2 completes the window centred on bordered (R-1,C-1), i.e. active (R-2,C-2). That handshake produces one output pixel; other handshakes produce none.
- Neighbours: L=(R-1,C-2), Rt=(R-1,C), U=(R-2,C-1), D=(R,C-1). "Good" means BAD_BIT=0. Values are compared with BAD_BIT masked off. Sums are 17 bits, then >>1, truncating.
- Centre good: output = centre.
- Centre bad, replacement priority:
  - L and Rt both good: (L+Rt)>>1.
  - Exactly one of L/Rt good: that neighbour.
  - U and D both good: (U+D)>>1.
  - Exactly one of U/D good: that neighbour.
  - None good: centre value with flag cleared.
- bad_cnt: internal 24-bit counter increments per bad centre and saturates at 2^24-1. It is copied to bad_cnt and cleared when the EOF output pixel is accepted.
- m_axis_tuser = 1 on output (0,0). m_axis_tlast = 1 on output (IMG_RES_Y-1, IMG_RES_X-1).
- Row check:
  - s_axis_tuser=1 with C≠IMG_RES_X+1 sets row_err and forces C←0 next; R advances as on a row end.
  - s_axis_tuser=0 at C=IMG_RES_X+1 sets row_err; counters wrap normally.
  - row_err clears only on reset.

## Timing
- Single output register stage. s_axis_tready = ~m_axis_tvalid | m_axis_tready, so there is no combinational path from s_axis_tvalid to outputs.
- Latency: an output is valid the cycle after the completing input handshake.
- While m_axis_tvalid=1 and m_axis_tready=0: tdata/tlast/tuser are held stable and s_axis_tready=0.
- Non-producing handshakes (border rows/cols) do not set m_axis_tvalid. They are accepted at full rate while the output register is empty or draining.
- Throughput is one pixel/cycle with m_axis_tready=1.
- Reset (asynchronous, any time, including mid-frame):
  - C, R, window registers and internal count are cleared.
  - Outputs: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, row_err=0, bad_cnt=0.
  - s_axis_tready=1 after reset.
  - Line buffer contents are not cleared. Stale data is overwritten by border row 0/1 before use.
- Simultaneous output accept and new producing handshake in the same cycle: the register reloads with no bubble.

## Test plan
- IMG_RES_X=4, IMG_RES_Y=3, border=16'h8000, ramp data 1..12, m_axis_tready=1 → outputs 1..12 in order, tuser on 1, tlast on 12, bad_cnt=0, row_err=0.
- Same frame with pixel (1,1)=16'h8000|99, neighbours L=5, Rt=7 → output 6, bad_cnt=1 after EOF.
- Pixel (0,0) bad: L is border, Rt=2 → output 2. Pixel (1,1) bad with L, Rt bad and U=2, D=10 → output 6.
- Random m_axis_tready (50%) over 3 frames → output stream identical to the stall-free run, no pixels lost or duplicated, tdata stable during stalls.
- s_axis_tuser asserted at C=3 in row 2 → row_err=1 and stays 1; the next frame after re-alignment outputs correct pixels.
- Assert axis_aresetn=0 mid-row 2 for 1 cycle → all outputs 0 immediately. A following full frame outputs 1..12 correctly with tuser on the first pixel.
